// File: rtl/ysyx_25040129_regfile_sb.sv
// rtl/ysyx_25040129_regfile_sb.sv - register file with per-register busy scoreboard
//
// Purpose: NREGS x XLEN architectural register file (x0 hard-wired to zero)
// with a busy bit per register. Issue claims a destination register, and
// writeback returns the data and releases the claim. Flush drops every
// outstanding claim but keeps register contents.
//
// Optional feature macro: YSYX_25040129_REGFILE_BYPASS_EN
//   defined   - a writeback in flight is forwarded to the read ports in the
//               same cycle, and the read port reports the register as not busy
//   undefined - reads return stored state; a writeback is visible next cycle
//
// Ports:
//   clk, rst               clock; synchronous active-high reset
//   rs1_id/rs2_id          read indices -> rs1_data/rs2_data, rs1_busy/rs2_busy
//   claim_valid/claim_rd   claim request -> claim_ready
//   wb_en/wb_rd/wb_data    writeback strobe, index and data
//   flush                  clear all busy bits
//   busy_cnt               registered count of busy registers
module ysyx_25040129_regfile_sb #(
  parameter int NREGS = 16,
  parameter int XLEN  = 32,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [AW-1:0]   rs1_id,
  input  logic [AW-1:0]   rs2_id,
  output logic [XLEN-1:0] rs1_data,
  output logic [XLEN-1:0] rs2_data,
  output logic            rs1_busy,
  output logic            rs2_busy,
  input  logic            claim_valid,
  input  logic [AW-1:0]   claim_rd,
  output logic            claim_ready,
  input  logic            wb_en,
  input  logic [AW-1:0]   wb_rd,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  output logic [AW:0]     busy_cnt
);

  logic [XLEN-1:0] regs_q [NREGS];
  logic [XLEN-1:0] regs_d [NREGS];
  logic [NREGS-1:0] busy_q, busy_d;
  logic [AW:0]      busy_cnt_q, busy_cnt_d;
  logic             wb_fire;
  logic             claim_fire;

  // A register being written back this cycle can be re-claimed in the same
  // cycle; the claim wins so the new owner sees it busy.
  assign claim_ready = !flush &&
                       (claim_rd == '0 || !busy_q[claim_rd] ||
                        (wb_en && wb_rd == claim_rd));

  assign wb_fire    = wb_en && (wb_rd != '0);
  assign claim_fire = claim_valid && claim_ready && (claim_rd != '0);

  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    if (wb_fire) begin
      regs_d[wb_rd] = wb_data;
      busy_d[wb_rd] = 1'b0;
    end
    if (claim_fire) begin
      busy_d[claim_rd] = 1'b1;
    end
    if (flush) begin
      busy_d = '0;
    end
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_d[i] = '0;
      end
      busy_d = '0;
    end
    // Count is derived from the next busy vector, so it always matches the
    // registered vector exactly; bit 0 is never set, so it stays <= NREGS-1.
    busy_cnt_d = '0;
    for (int i = 0; i < NREGS; i++) begin
      busy_cnt_d = busy_cnt_d + (AW+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    regs_q     <= regs_d;
    busy_q     <= busy_d;
    busy_cnt_q <= busy_cnt_d;
  end

  assign busy_cnt = busy_cnt_q;

`ifdef YSYX_25040129_REGFILE_BYPASS_EN
  always_comb begin
    rs1_data = '0;
    rs1_busy = 1'b0;
    rs2_data = '0;
    rs2_busy = 1'b0;
    if (rs1_id != '0) begin
      if (wb_en && wb_rd == rs1_id) begin
        rs1_data = wb_data;
      end else begin
        rs1_data = regs_q[rs1_id];
        rs1_busy = busy_q[rs1_id];
      end
    end
    if (rs2_id != '0) begin
      if (wb_en && wb_rd == rs2_id) begin
        rs2_data = wb_data;
      end else begin
        rs2_data = regs_q[rs2_id];
        rs2_busy = busy_q[rs2_id];
      end
    end
  end
`else
  assign rs1_data = (rs1_id == '0) ? '0 : regs_q[rs1_id];
  assign rs2_data = (rs2_id == '0) ? '0 : regs_q[rs2_id];
  assign rs1_busy = (rs1_id != '0) && busy_q[rs1_id];
  assign rs2_busy = (rs2_id != '0) && busy_q[rs2_id];
`endif

endmodule

// File: tb/tb_ysyx_25040129_regfile_sb.sv
// tb/tb_ysyx_25040129_regfile_sb.sv - directed self-checking bench for the scoreboarded regfile
module tb_ysyx_25040129_regfile_sb;

  logic        clk;
  logic        rst;
  logic [3:0]  rs1_id, rs2_id, claim_rd, wb_rd;
  logic [31:0] rs1_data, rs2_data, wb_data;
  logic        rs1_busy, rs2_busy, claim_valid, claim_ready, wb_en, flush;
  logic [4:0]  busy_cnt;

  logic [4:0]  b_rs1_id, b_rs2_id, b_claim_rd, b_wb_rd;
  logic [31:0] b_rs1_data, b_rs2_data, b_wb_data;
  logic        b_rs1_busy, b_rs2_busy, b_claim_valid, b_claim_ready, b_wb_en, b_flush;
  logic [5:0]  b_busy_cnt;

  int checks = 0;
  int failures = 0;

  ysyx_25040129_regfile_sb u_dut (
    .clk(clk), .rst(rst),
    .rs1_id(rs1_id), .rs2_id(rs2_id),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .claim_valid(claim_valid), .claim_rd(claim_rd), .claim_ready(claim_ready),
    .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .flush(flush), .busy_cnt(busy_cnt)
  );

  ysyx_25040129_regfile_sb #(.NREGS(32), .XLEN(32)) u_dut32 (
    .clk(clk), .rst(rst),
    .rs1_id(b_rs1_id), .rs2_id(b_rs2_id),
    .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
    .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy),
    .claim_valid(b_claim_valid), .claim_rd(b_claim_rd), .claim_ready(b_claim_ready),
    .wb_en(b_wb_en), .wb_rd(b_wb_rd), .wb_data(b_wb_data),
    .flush(b_flush), .busy_cnt(b_busy_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle inputs away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    claim_valid = 0; claim_rd = 0; wb_en = 0; wb_rd = 0; wb_data = 0; flush = 0;
    b_claim_valid = 0; b_claim_rd = 0; b_wb_en = 0; b_wb_rd = 0; b_wb_data = 0; b_flush = 0;
  endtask

  initial begin
    rs1_id = 0; rs2_id = 0; b_rs1_id = 0; b_rs2_id = 0;
    idle();
    rst = 1;
    tick();
    tick();
    rst = 0;

    // Reset state over every index
    claim_rd = 4'd5;
    for (int i = 0; i < 16; i++) begin
      rs1_id = 4'(i); rs2_id = 4'(15 - i);
      #1;
      check($sformatf("rst_rs1_data[%0d]", i), rs1_data, 32'h0);
      check($sformatf("rst_rs2_data[%0d]", 15 - i), rs2_data, 32'h0);
      check($sformatf("rst_rs1_busy[%0d]", i), {31'b0, rs1_busy}, 32'h0);
      check($sformatf("rst_rs2_busy[%0d]", 15 - i), {31'b0, rs2_busy}, 32'h0);
    end
    check("rst_busy_cnt", {27'b0, busy_cnt}, 32'd0);
    check("rst_claim_ready", {31'b0, claim_ready}, 32'd1);

    // Preload x5 with a known old value
    idle();
    wb_en = 1; wb_rd = 5; wb_data = 32'h11111111;
    tick();
    idle();

    // Claim x5, then hold the claim while it is busy
    claim_valid = 1; claim_rd = 5;
    tick();
    rs1_id = 5;
    @(negedge clk);
    check("claim5_ready_low", {31'b0, claim_ready}, 32'd0);
    check("claim5_busy_cnt", {27'b0, busy_cnt}, 32'd1);
    check("claim5_rs1_busy", {31'b0, rs1_busy}, 32'd1);
    tick();
    check("claim5_hold_cnt", {27'b0, busy_cnt}, 32'd1);

    // Writeback x5
    idle();
    wb_en = 1; wb_rd = 5; wb_data = 32'hDEADBEEF;
    @(negedge clk);
`ifdef YSYX_25040129_REGFILE_BYPASS_EN
    check("wb5_same_data", rs1_data, 32'hDEADBEEF);
    check("wb5_same_busy", {31'b0, rs1_busy}, 32'd0);
`else
    check("wb5_same_data", rs1_data, 32'h11111111);
    check("wb5_same_busy", {31'b0, rs1_busy}, 32'd1);
`endif
    tick();
    idle();
    #1;
    check("wb5_next_data", rs1_data, 32'hDEADBEEF);
    check("wb5_next_busy", {31'b0, rs1_busy}, 32'd0);
    check("wb5_busy_cnt", {27'b0, busy_cnt}, 32'd0);

    // Claim x7, then claim and writeback x7 together
    claim_valid = 1; claim_rd = 7;
    tick();
    check("claim7_cnt", {27'b0, busy_cnt}, 32'd1);
    wb_en = 1; wb_rd = 7; wb_data = 32'h12345678;
    @(negedge clk);
    check("claim_wb7_ready", {31'b0, claim_ready}, 32'd1);
    tick();
    idle();
    rs1_id = 7;
    #1;
    check("claim_wb7_data", rs1_data, 32'h12345678);
    check("claim_wb7_busy", {31'b0, rs1_busy}, 32'd1);
    check("claim_wb7_cnt", {27'b0, busy_cnt}, 32'd1);

    // Release x7, claim x1..x3
    wb_en = 1; wb_rd = 7; wb_data = 32'h77777777;
    tick();
    idle();
    check("rel7_cnt", {27'b0, busy_cnt}, 32'd0);
    for (int r = 1; r <= 3; r++) begin
      claim_valid = 1; claim_rd = 4'(r);
      tick();
      check($sformatf("claim%0d_cnt", r), {27'b0, busy_cnt}, 32'(r));
    end

    // Flush with a simultaneous writeback of x2
    idle();
    flush = 1; wb_en = 1; wb_rd = 2; wb_data = 32'hA5A5A5A5;
    claim_valid = 1; claim_rd = 4;
    @(negedge clk);
    check("flush_claim_ready", {31'b0, claim_ready}, 32'd0);
    tick();
    idle();
    rs1_id = 2; rs2_id = 4;
    #1;
    check("flush_cnt", {27'b0, busy_cnt}, 32'd0);
    check("flush_x2_data", rs1_data, 32'hA5A5A5A5);
    check("flush_x2_busy", {31'b0, rs1_busy}, 32'd0);
    check("flush_x4_busy", {31'b0, rs2_busy}, 32'd0);
    rs1_id = 7;
    #1;
    check("flush_x7_kept", rs1_data, 32'h77777777);

    // Writeback and claim of x0
    wb_en = 1; wb_rd = 0; wb_data = 32'hFFFFFFFF;
    claim_valid = 1; claim_rd = 0;
    @(negedge clk);
    check("x0_claim_ready", {31'b0, claim_ready}, 32'd1);
    tick();
    idle();
    rs1_id = 0;
    #1;
    check("x0_data", rs1_data, 32'h0);
    check("x0_busy", {31'b0, rs1_busy}, 32'd0);
    check("x0_cnt", {27'b0, busy_cnt}, 32'd0);

    // Mid-operation reset overrides claim and writeback
    claim_valid = 1; claim_rd = 9;
    tick();
    check("claim9_cnt", {27'b0, busy_cnt}, 32'd1);
    claim_valid = 1; claim_rd = 10; wb_en = 1; wb_rd = 3; wb_data = 32'h55555555;
    rst = 1;
    tick();
    rst = 0;
    idle();
    rs1_id = 3; rs2_id = 9;
    #1;
    check("rst_mid_x3_data", rs1_data, 32'h0);
    check("rst_mid_x9_busy", {31'b0, rs2_busy}, 32'd0);
    check("rst_mid_cnt", {27'b0, busy_cnt}, 32'd0);
    rs1_id = 2; rs2_id = 10;
    #1;
    check("rst_mid_x2_data", rs1_data, 32'h0);
    check("rst_mid_x10_busy", {31'b0, rs2_busy}, 32'd0);

    // 32-register build: top register x31
    b_claim_valid = 1; b_claim_rd = 5'd31;
    tick();
    b_claim_valid = 0;
    b_rs1_id = 5'd31;
    #1;
    check("r32_claim31_cnt", {26'b0, b_busy_cnt}, 32'd1);
    check("r32_claim31_busy", {31'b0, b_rs1_busy}, 32'd1);
    b_wb_en = 1; b_wb_rd = 5'd31; b_wb_data = 32'hCAFEF00D;
    tick();
    idle();
    #1;
    check("r32_x31_data", b_rs1_data, 32'hCAFEF00D);
    check("r32_x31_cnt", {26'b0, b_busy_cnt}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
